// File: rtl/br_resolve_ctrl_if.sv
// Branch-resolve channel between the EX stage, fetch, and the branch predictor.
// The pipeline side uses the master modport; br_resolve_ctrl uses the slave modport.
interface br_resolve_ctrl_if;
  logic        i_br_valid_e;
  logic        i_br_taken_e;
  logic        i_pred_taken_e;
  logic [31:0] i_pc_e;
  logic [31:0] i_target_e;
  logic [31:0] i_pred_target_e;
  logic        i_upd_ready;

  logic        o_stall;
  logic        o_flush;
  logic        o_redirect_valid;
  logic [31:0] o_redirect_pc;
  logic        o_upd_valid;
  logic [31:0] o_upd_pc;
  logic        o_upd_taken;
  logic [31:0] o_upd_target;
  logic [31:0] o_br_cnt;
  logic [31:0] o_mispred_cnt;

  modport master (
    output i_br_valid_e, i_br_taken_e, i_pred_taken_e, i_pc_e, i_target_e,
           i_pred_target_e, i_upd_ready,
    input  o_stall, o_flush, o_redirect_valid, o_redirect_pc, o_upd_valid,
           o_upd_pc, o_upd_taken, o_upd_target, o_br_cnt, o_mispred_cnt
  );

  modport slave (
    input  i_br_valid_e, i_br_taken_e, i_pred_taken_e, i_pc_e, i_target_e,
           i_pred_target_e, i_upd_ready,
    output o_stall, o_flush, o_redirect_valid, o_redirect_pc, o_upd_valid,
           o_upd_pc, o_upd_taken, o_upd_target, o_br_cnt, o_mispred_cnt
  );
endinterface

// File: rtl/br_resolve_ctrl.sv
// EX-stage branch resolution: misprediction redirect/flush FSM plus a predictor-update FIFO.
// Optional performance counters are built when BR_PERF_CNT_EN is defined.
module br_resolve_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  br_resolve_ctrl_if.slave         io_bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH1 = 2'd1,
    ST_FLUSH2 = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
  } upd_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic           w_flush;

  upd_t           r_queue [DEPTH];
  logic [AW-1:0]  r_wr_ptr;
  logic [AW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic           r_redirect_valid;
  logic [31:0]    r_redirect_pc;

  logic           w_empty;
  logic           w_full;
  logic           w_deq;
  logic           w_enq;
  logic           w_stall;
  logic           w_accept;
  logic           w_mispred;
  upd_t           w_head;

  // Queue status and the combinational hold request towards EX.
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CW'(DEPTH));
  assign w_deq   = !w_empty && io_bus.i_upd_ready;
  assign w_stall = io_bus.i_br_valid_e && w_full && !w_deq;

  // Branches seen while flushing are wrong-path and never accepted.
  assign w_accept  = io_bus.i_br_valid_e && !w_stall && (r_state == ST_IDLE);
  assign w_mispred = w_accept &&
                     ((io_bus.i_br_taken_e != io_bus.i_pred_taken_e) ||
                      (io_bus.i_br_taken_e && (io_bus.i_target_e != io_bus.i_pred_target_e)));
  assign w_enq     = w_accept;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_nxt = r_state;
    w_flush     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_mispred) w_state_nxt = ST_FLUSH1;
      end
      ST_FLUSH1: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_FLUSH2;
      end
      ST_FLUSH2: begin
        w_flush     = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispred;
      if (w_mispred) begin
        r_redirect_pc <= io_bus.i_br_taken_e ? io_bus.i_target_e : (io_bus.i_pc_e + 32'd4);
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
      unique case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: queue storage is not reset; entries are only observed while the occupancy count covers them.
  always_ff @(posedge i_clk) begin
    if (w_enq) begin
      r_queue[r_wr_ptr] <= '{pc:     io_bus.i_pc_e,
                             taken:  io_bus.i_br_taken_e,
                             target: io_bus.i_target_e};
    end
  end

  assign w_head = r_queue[r_rd_ptr];

`ifdef BR_PERF_CNT_EN
  logic [31:0] r_br_cnt;
  logic [31:0] r_mispred_cnt;

  // Saturating counters: hold at all-ones rather than wrap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else begin
      if (w_accept && (r_br_cnt != 32'hFFFF_FFFF))       r_br_cnt      <= r_br_cnt + 32'd1;
      if (w_mispred && (r_mispred_cnt != 32'hFFFF_FFFF)) r_mispred_cnt <= r_mispred_cnt + 32'd1;
    end
  end

  assign io_bus.o_br_cnt      = r_br_cnt;
  assign io_bus.o_mispred_cnt = r_mispred_cnt;
`else
  assign io_bus.o_br_cnt      = '0;
  assign io_bus.o_mispred_cnt = '0;
`endif

  assign io_bus.o_stall          = w_stall;
  assign io_bus.o_flush          = w_flush;
  assign io_bus.o_redirect_valid = r_redirect_valid;
  assign io_bus.o_redirect_pc    = r_redirect_pc;
  assign io_bus.o_upd_valid      = !w_empty;
  assign io_bus.o_upd_pc         = w_head.pc;
  assign io_bus.o_upd_taken      = w_head.taken;
  assign io_bus.o_upd_target     = w_head.target;

endmodule

// File: tb/tb_br_resolve_ctrl.sv
// Self-checking bench for br_resolve_ctrl: directed vector table, corner sequences,
// and random traffic against a queue-based reference model.
module tb_br_resolve_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic        valid;
    logic        taken;
    logic        pred;
    logic [31:0] pc;
    logic [31:0] tgt;
    logic [31:0] ptgt;
    logic        ready;
    logic        rst;
  } in_t;

  typedef struct {
    in_t         in;
    logic        exp_stall;
    logic        exp_flush;
    logic        exp_rv;
    logic [31:0] exp_rpc;
    logic        exp_uv;
    logic [31:0] exp_upc;
    logic        exp_ut;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] tgt;
  } upd_t;

  logic clk;
  logic rst;
  br_resolve_ctrl_if bus ();

  br_resolve_ctrl #(.DEPTH(DEPTH)) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: pending updates, flush cycles remaining, redirect, event counts.
  upd_t        mq[$];
  int          m_flush_left = 0;
  logic        m_rv = 1'b0;
  logic [31:0] m_rpc = '0;
  longint      m_br = 0;
  longint      m_mis = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [31:0] cnt_port(input longint v);
`ifdef BR_PERF_CNT_EN
    return (v > 64'hFFFF_FFFF) ? 32'hFFFF_FFFF : v[31:0];
`else
    return (v < 0) ? 32'd1 : 32'd0;
`endif
  endfunction

  function automatic logic model_stall(input in_t s);
    int sz = mq.size();
    return s.valid && (sz == DEPTH) && !((sz != 0) && s.ready);
  endfunction

  task automatic drive(input in_t s);
    bus.i_br_valid_e    = s.valid;
    bus.i_br_taken_e    = s.taken;
    bus.i_pred_taken_e  = s.pred;
    bus.i_pc_e          = s.pc;
    bus.i_target_e      = s.tgt;
    bus.i_pred_target_e = s.ptgt;
    bus.i_upd_ready     = s.ready;
    rst                 = s.rst;
  endtask

  task automatic model_check(input in_t s);
    check("stall", {31'd0, bus.o_stall}, {31'd0, model_stall(s)});
    check("flush", {31'd0, bus.o_flush}, {31'd0, m_flush_left != 0});
    check("redirect_valid", {31'd0, bus.o_redirect_valid}, {31'd0, m_rv});
    check("redirect_pc", bus.o_redirect_pc, m_rpc);
    check("upd_valid", {31'd0, bus.o_upd_valid}, {31'd0, mq.size() != 0});
    if (mq.size() != 0) begin
      check("upd_pc", bus.o_upd_pc, mq[0].pc);
      check("upd_taken", {31'd0, bus.o_upd_taken}, {31'd0, mq[0].taken});
      check("upd_target", bus.o_upd_target, mq[0].tgt);
    end
    check("br_cnt", bus.o_br_cnt, cnt_port(m_br));
    check("mispred_cnt", bus.o_mispred_cnt, cnt_port(m_mis));
  endtask

  task automatic model_update(input in_t s);
    logic stall, acc, mis;
    stall = model_stall(s);
    if (s.rst) begin
      mq.delete();
      m_flush_left = 0;
      m_rv  = 1'b0;
      m_rpc = '0;
      m_br  = 0;
      m_mis = 0;
    end else begin
      acc = s.valid && !stall && (m_flush_left == 0);
      mis = acc && ((s.taken != s.pred) || (s.taken && (s.tgt != s.ptgt)));
      if ((mq.size() != 0) && s.ready) void'(mq.pop_front());
      if (acc) mq.push_back('{pc: s.pc, taken: s.taken, tgt: s.tgt});
      m_flush_left = mis ? 2 : ((m_flush_left > 0) ? m_flush_left - 1 : 0);
      m_rv = mis;
      if (mis) m_rpc = s.taken ? s.tgt : s.pc + 32'd4;
      if (acc) m_br++;
      if (mis) m_mis++;
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1 unit later.
  task automatic pre(input in_t s);
    drive(s);
    #1;
    model_check(s);
  endtask

  task automatic advance(input in_t s);
    model_update(s);
    @(posedge clk);
    #1;
  endtask

  task automatic step(input in_t s);
    pre(s);
    advance(s);
  endtask

  function automatic in_t br(input logic v, t, p, input logic [31:0] pc, tgt, ptgt,
                             input logic rdy, rst_in);
    in_t s;
    s.valid = v; s.taken = t; s.pred = p; s.pc = pc; s.tgt = tgt; s.ptgt = ptgt;
    s.ready = rdy; s.rst = rst_in;
    return s;
  endfunction

  function automatic vec_t vec(input in_t s, input logic st, fl, rv, input logic [31:0] rpc,
                               input logic uv, input logic [31:0] upc, input logic ut);
    vec_t v;
    v.in = s; v.exp_stall = st; v.exp_flush = fl; v.exp_rv = rv; v.exp_rpc = rpc;
    v.exp_uv = uv; v.exp_upc = upc; v.exp_ut = ut;
    return v;
  endfunction

  vec_t vecs[13];
  in_t  idle_r, idle_n, s;
  logic [31:0] exp_order[4];

  initial begin
    idle_r = br(0, 0, 0, 0, 0, 0, 1, 0);
    idle_n = br(0, 0, 0, 0, 0, 0, 0, 0);

    // Expected outputs are those seen before the edge at which the row's inputs are taken.
    vecs[0]  = vec(br(1, 0, 0, 32'h100, 32'h104, 0, 1, 0),         0, 0, 0, 32'h0,  0, 0, 0);
    vecs[1]  = vec(br(0, 0, 0, 0, 0, 0, 0, 0),                     0, 0, 0, 32'h0,  1, 32'h100, 0);
    vecs[2]  = vec(br(1, 1, 0, 32'h200, 32'h80, 0, 1, 0),          0, 0, 0, 32'h0,  1, 32'h100, 0);
    vecs[3]  = vec(br(1, 1, 1, 32'h300, 32'h300, 32'h300, 0, 0),   0, 1, 1, 32'h80, 1, 32'h200, 1);
    vecs[4]  = vec(br(1, 1, 1, 32'h300, 32'h300, 32'h300, 1, 0),   0, 1, 0, 32'h80, 1, 32'h200, 1);
    vecs[5]  = vec(br(0, 0, 0, 0, 0, 0, 1, 0),                     0, 0, 0, 32'h80, 0, 0, 0);
    vecs[6]  = vec(br(1, 0, 1, 32'hFFFF_FFFC, 32'h10, 32'h10, 1, 0), 0, 0, 0, 32'h80, 0, 0, 0);
    vecs[7]  = vec(br(0, 0, 0, 0, 0, 0, 1, 0),                     0, 1, 1, 32'h0,  1, 32'hFFFF_FFFC, 0);
    vecs[8]  = vec(br(0, 0, 0, 0, 0, 0, 1, 0),                     0, 1, 0, 32'h0,  0, 0, 0);
    vecs[9]  = vec(br(1, 1, 1, 32'h400, 32'h500, 32'h504, 1, 0),   0, 0, 0, 32'h0,  0, 0, 0);
    vecs[10] = vec(br(0, 0, 0, 0, 0, 0, 1, 0),                     0, 1, 1, 32'h500, 1, 32'h400, 1);
    vecs[11] = vec(br(0, 0, 0, 0, 0, 0, 1, 0),                     0, 1, 0, 32'h500, 0, 0, 0);
    vecs[12] = vec(br(0, 0, 0, 0, 0, 0, 1, 0),                     0, 0, 0, 32'h500, 0, 0, 0);

    // Power-on reset: outputs are not compared until the first reset edge has passed.
    drive(br(0, 0, 0, 0, 0, 0, 0, 1));
    repeat (2) @(posedge clk);
    #1;

    // Directed table: correct branch, taken mispredict with wrong-path traffic, PC wrap,
    // and a taken branch whose only error is the target.
    for (int i = 0; i < 13; i++) begin
      pre(vecs[i].in);
      check($sformatf("vec%0d_stall", i), {31'd0, bus.o_stall}, {31'd0, vecs[i].exp_stall});
      check($sformatf("vec%0d_flush", i), {31'd0, bus.o_flush}, {31'd0, vecs[i].exp_flush});
      check($sformatf("vec%0d_rv", i), {31'd0, bus.o_redirect_valid}, {31'd0, vecs[i].exp_rv});
      check($sformatf("vec%0d_rpc", i), bus.o_redirect_pc, vecs[i].exp_rpc);
      check($sformatf("vec%0d_uv", i), {31'd0, bus.o_upd_valid}, {31'd0, vecs[i].exp_uv});
      if (vecs[i].exp_uv) begin
        check($sformatf("vec%0d_upc", i), bus.o_upd_pc, vecs[i].exp_upc);
        check($sformatf("vec%0d_ut", i), {31'd0, bus.o_upd_taken}, {31'd0, vecs[i].exp_ut});
      end
      advance(vecs[i].in);
    end
`ifdef BR_PERF_CNT_EN
    check("table_br_cnt", bus.o_br_cnt, 32'd4);
    check("table_mispred_cnt", bus.o_mispred_cnt, 32'd3);
`else
    check("table_br_cnt", bus.o_br_cnt, 32'd0);
    check("table_mispred_cnt", bus.o_mispred_cnt, 32'd0);
`endif

    // Full queue with predictor not ready: fifth branch stalls until ready rises.
    for (int i = 0; i < 4; i++) step(br(1, 0, 0, 32'h1000 + 32'(4 * i), 0, 0, 0, 0));
    s = br(1, 0, 0, 32'h2000, 0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      pre(s);
      check("full_stall", {31'd0, bus.o_stall}, 32'd1);
      check("full_head_pc", bus.o_upd_pc, 32'h1000);
      advance(s);
    end
    s.ready = 1'b1;
    pre(s);
    check("full_ready_stall", {31'd0, bus.o_stall}, 32'd0);
    advance(s);
    exp_order = '{32'h1004, 32'h1008, 32'h100C, 32'h2000};
    for (int i = 0; i < 4; i++) begin
      pre(idle_r);
      check("drain_valid", {31'd0, bus.o_upd_valid}, 32'd1);
      check("drain_order", bus.o_upd_pc, exp_order[i]);
      advance(idle_r);
    end
    step(idle_r);

    // Reset during FLUSH1 with three queued updates discards everything.
    step(br(1, 0, 0, 32'h3000, 0, 0, 0, 0));
    step(br(1, 0, 0, 32'h3004, 0, 0, 0, 0));
    step(br(1, 1, 0, 32'h3008, 32'h40, 0, 0, 0));
    s = br(0, 0, 0, 0, 0, 0, 0, 1);
    pre(s);
    check("rst_in_flush1", {31'd0, bus.o_flush}, 32'd1);
    advance(s);
    pre(idle_n);
    check("rst_flush", {31'd0, bus.o_flush}, 32'd0);
    check("rst_upd_valid", {31'd0, bus.o_upd_valid}, 32'd0);
    check("rst_rv", {31'd0, bus.o_redirect_valid}, 32'd0);
    check("rst_rpc", bus.o_redirect_pc, 32'd0);
    check("rst_br_cnt", bus.o_br_cnt, 32'd0);
    check("rst_mis_cnt", bus.o_mispred_cnt, 32'd0);
    advance(idle_n);

    // Random traffic against the reference model.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] t;
      s.valid = ($urandom_range(0, 9) < 7);
      s.taken = $urandom_range(0, 1) == 1;
      s.pred  = ($urandom_range(0, 3) == 0) ? !s.taken : s.taken;
      s.pc    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 15) == 0) s.pc = 32'hFFFF_FFFC;
      t       = $urandom & 32'hFFFF_FFFC;
      s.tgt   = t;
      s.ptgt  = ($urandom_range(0, 3) == 0) ? t ^ 32'h10 : t;
      s.ready = ($urandom_range(0, 9) < 5);
      s.rst   = ($urandom_range(0, 149) == 0);
      step(s);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/br_resolve_ctrl.md
BR_RESOLVE_CTRL -- requirements
Module: br_resolve_ctrl

Interface
REQ-001 Parameter DEPTH, default 4, update-queue entries; power of two, at least 2.
REQ-002 i_clk  input  1  clock; all state updates on rising edge.
REQ-003 i_rst  input  1  reset, synchronous, active-high.
REQ-004 i_br_valid_e  input  1  EX stage holds a resolved branch or jump this cycle.
REQ-005 i_br_taken_e  input  1  actual branch outcome.
REQ-006 i_pred_taken_e  input  1  prediction carried with the instruction.
REQ-007 i_pc_e  input  32  branch PC.
REQ-008 i_target_e  input  32  resolved target.
REQ-009 i_pred_target_e  input  32  predicted target.
REQ-010 i_upd_ready  input  1  predictor accepts an update this cycle.
REQ-011 o_stall  output  1  hold EX; branch not accepted this cycle.
REQ-012 o_flush  output  1  squash IF/ID contents.
REQ-013 o_redirect_valid  output  1  fetch redirect strobe.
REQ-014 o_redirect_pc  output  32  corrected fetch PC.
REQ-015 o_upd_valid, o_upd_pc[31:0], o_upd_taken, o_upd_target[31:0]  output  predictor-update channel.
REQ-016 o_br_cnt  output  32  accepted-branch count.
REQ-017 o_mispred_cnt  output  32  misprediction count.

Function
REQ-018 Accept = i_br_valid_e && !o_stall && state==IDLE; only accepted branches are counted, queued or checked.
REQ-019 Mispredict = accept && (i_br_taken_e != i_pred_taken_e || (i_br_taken_e && i_target_e != i_pred_target_e)).
REQ-020 FSM states IDLE, FLUSH1, FLUSH2; IDLE->FLUSH1 on mispredict; FLUSH1->FLUSH2 unconditionally; FLUSH2->IDLE unconditionally.
REQ-021 Mispredict at edge N: o_redirect_valid high for exactly the cycle after N; o_redirect_pc = i_target_e if taken, else i_pc_e+4 (mod 2^32), registered at N.
REQ-022 o_flush high exactly in FLUSH1 and FLUSH2; i_br_valid_e in those states is a wrong-path branch, silently ignored (no queue, no count).
REQ-023 Every accepted branch, correct or not, is written into the update queue at the same edge.
REQ-024 Queue FIFO order; o_upd_valid = not empty; head fields drive o_upd_*; transfer on o_upd_valid && i_upd_ready; outputs stable while valid && !ready.
REQ-025 o_stall = i_br_valid_e && queue full && !(o_upd_valid && i_upd_ready) (combinational); simultaneous enqueue and dequeue when full is permitted, count unchanged.
REQ-026 Pointers wrap modulo DEPTH; occupancy counter range 0..DEPTH, never overflows or underflows.
REQ-027 Queue drains during FLUSH1/FLUSH2 independently of the FSM.

Reset
REQ-028 i_rst high at any edge: state IDLE, queue empty, o_flush, o_redirect_valid, o_upd_valid 0, o_redirect_pc 0, counters 0; in-flight flush and queued updates discarded.
REQ-029 During reset o_stall follows REQ-025 with empty queue, hence 0.

Configuration
REQ-030 Macro BR_PERF_CNT_EN defined: o_br_cnt increments per accepted branch, o_mispred_cnt per mispredict, both saturate at 32'hFFFF_FFFF.
REQ-031 BR_PERF_CNT_EN undefined: counter registers absent; both ports tied to 0; all other behaviour identical.

Verification
REQ-032 Correct not-taken, pc 0x100, pred 0, ready 1 -> no flush/redirect; next cycle o_upd_valid=1, o_upd_pc=0x100, o_upd_taken=0.
REQ-033 Taken branch pc 0x200, target 0x80, pred 0 -> redirect 1 cycle with pc 0x80; o_flush 2 cycles; branch presented during flush cycles not queued; o_mispred_cnt=1 (macro on).
REQ-034 Not-taken, pred taken, pc 0xFFFF_FFFC -> o_redirect_pc=0x0000_0000.
REQ-035 i_upd_ready=0, 4 correct branches then a 5th -> o_stall=1, head fields stable; raise ready -> 5th accepted same cycle, order preserved.
REQ-036 Assert i_rst in FLUSH1 with 3 queued -> next cycle o_flush=0, o_upd_valid=0, counters 0.
